// File: rtl/alu_cmd_issuer_if.sv
// alu_pkg: ALU_IO command struct shared with alu_8bit.
// alu_cmd_issuer_if: command, response and ALU-side signals of alu_cmd_issuer.
package alu_pkg;
    localparam int ALU_WIDTH = 8;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_NOT,
        ALU_SHL,
        ALU_SHR
    } alu_op_e;

    typedef struct packed {
        logic [ALU_WIDTH-1:0] A;
        logic [ALU_WIDTH-1:0] B;
        alu_op_e              operation;
        logic                 cin;
    } ALU_IO;
endpackage

interface alu_cmd_issuer_if #(
    parameter int WIDTH = alu_pkg::ALU_WIDTH
);
    import alu_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    alu_op_e          cmd_op;
    logic             cmd_cin;
    logic             cmd_chain;

    ALU_IO            alu_drive;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_carry;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_cin, cmd_chain, rsp_ready,
        output alu_result, alu_carry,
        input  cmd_ready, rsp_valid, rsp_result, rsp_carry, alu_drive
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_cin, cmd_chain, rsp_ready,
        input  alu_result, alu_carry,
        output cmd_ready, rsp_valid, rsp_result, rsp_carry, alu_drive
    );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Buffers ALU commands, drives ALU_IO one op at a time, returns result/carry on a valid/ready channel.
// Optional statistics counters enabled by defining ALU_ISSUER_STATS_EN.
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_cmd_issuer_if.slave bus
`ifdef ALU_ISSUER_STATS_EN
    ,
    output logic [15:0]     stat_ops,
    output logic [15:0]     stat_carries
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        alu_op_e          op;
        logic             cin;
        logic             chain;
    } entry_t;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

    state_e        state;
    state_e        state_nxt;
    entry_t        fifo [DEPTH];
    entry_t        head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          not_empty;
    logic          push;
    logic          pop;
    logic          capture;
    logic          carry_hist;

    assign head          = fifo[rd_ptr];
    assign not_empty     = (count != '0);
    assign bus.cmd_ready = (count != CW'(DEPTH));
    assign push          = bus.cmd_valid && bus.cmd_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (not_empty) state_nxt = ISSUE;
            ISSUE:   state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = not_empty ? ISSUE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pop decisions use the registered count, so a push never bypasses into the same edge's pop.
    always_comb begin
        pop     = 1'b0;
        capture = 1'b0;
        case (state)
            IDLE:    pop = not_empty;
            ISSUE:   capture = 1'b1;
            RESP:    pop = bus.rsp_ready && not_empty;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo[wr_ptr] <= '{a: bus.cmd_a, b: bus.cmd_b, op: bus.cmd_op,
                              cin: bus.cmd_cin, chain: bus.cmd_chain};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Chained cin is resolved at pop time; the previous op has always been captured by then.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.alu_drive  <= '0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_result <= '0;
            bus.rsp_carry  <= 1'b0;
            carry_hist     <= 1'b0;
        end else begin
            if (pop) begin
                bus.alu_drive <= '{A: head.a, B: head.b, operation: head.op,
                                   cin: head.chain ? carry_hist : head.cin};
            end
            if (capture) begin
                bus.rsp_result <= bus.alu_result;
                bus.rsp_carry  <= bus.alu_carry;
                bus.rsp_valid  <= 1'b1;
                carry_hist     <= bus.alu_carry;
            end else if (state == RESP && bus.rsp_ready) begin
                bus.rsp_valid  <= 1'b0;
            end
        end
    end

`ifdef ALU_ISSUER_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_ops     <= '0;
            stat_carries <= '0;
        end else if (capture) begin
            if (stat_ops != '1) stat_ops <= stat_ops + 16'd1;
            if (bus.alu_carry && stat_carries != '1) stat_carries <= stat_carries + 16'd1;
        end
    end
`endif

endmodule
